bl_wl_programmer: RTL and testbench
===================================

Name: bl_wl_programmer

Overview:
- Configuration-side driver that sits directly upstream of a memory-bank array of sram_blwl / SRAMR-family cells.
- Accepts one row-write (or array-clear) request per valid/ready handshake.
- Sequences the bit lines (BL), word lines (WL) and the shared cell reset with fixed setup/pulse/hold timing, so that each addressed row latches its data cleanly.

Parameters:
- NUM_BL, 8, number of bit lines (row width in bits); must be >= 1.
- NUM_WL, 8, number of word lines (rows); must be >= 2.
- WL_ADDR_W, 3, width of the row address; must satisfy 2**WL_ADDR_W >= NUM_WL.
- SETUP_CYCLES, 1, cycles BL is stable before WL rises; must be >= 1.
- PULSE_CYCLES, 2, cycles WL (or sram_rst) is held high; must be >= 1.

Ports:
- prog_clk  in  1  programming clock; all state updates on its rising edge.
- RSTN  in  1  reset, asynchronous assert, active low.
- cfg_valid  in  1  request valid.
- cfg_ready  out  1  request accepted on a prog_clk edge when cfg_valid && cfg_ready.
- cfg_clear  in  1  qualifies the request: 1 = clear the whole array, 0 = row write.
- cfg_wl_addr  in  WL_ADDR_W  target row; ignored when cfg_clear = 1.
- cfg_data  in  NUM_BL  row data; bit i drives bl[i].
- bl  out  [0:NUM_BL-1]  bit lines; index 0 is the LSB.
- wl  out  [0:NUM_WL-1]  word lines; index 0 is the LSB; at most one bit high at any time.
- sram_rst  out  1  active-high reset to all cells.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a write or clear completes.
- err  out  1  one-cycle pulse on an out-of-range address.

Behaviour:
- Reset (RSTN = 0, asynchronous): state = IDLE, counter = 0, bl = 0, wl = 0, sram_rst = 0, busy = 0, done = 0, err = 0.
  - cfg_ready = 1 only once RSTN is high; cfg_ready is 0 while RSTN = 0.
  - Assertion mid-operation aborts immediately: all lines drop in the same instant and no done is produced.
- cfg_ready = (state == IDLE). All outputs are registered. cfg_* inputs are sampled only at the handshake edge.
- States: IDLE, SETUP, PULSE, HOLD, CLR, ERR.
- IDLE, on handshake:
  - cfg_clear = 1 -> CLR.
  - Otherwise, cfg_wl_addr >= NUM_WL -> ERR.
  - Otherwise -> SETUP; latch addr and data; bl <= cfg_data.
- SETUP: bl = latched data, wl = 0. Stays SETUP_CYCLES cycles, then -> PULSE.
- PULSE: wl[addr] = 1, bl unchanged. Stays PULSE_CYCLES cycles, then -> HOLD.
- HOLD: wl = 0, bl still held for exactly 1 cycle, then -> IDLE with bl <= 0 and done = 1 in that first IDLE cycle.
- CLR: sram_rst = 1, bl = 0, wl = 0 for PULSE_CYCLES cycles, then -> IDLE with sram_rst = 0 and done = 1.
- ERR: 1 cycle; bl, wl and sram_rst stay 0. Then -> IDLE with err = 1 and done = 0.
- Latency from handshake edge to the done cycle:
  - Row write: SETUP_CYCLES + PULSE_CYCLES + 1 cycles of busy (4 at defaults).
  - Clear: PULSE_CYCLES busy cycles.
  - Error: 1 busy cycle.
- Back-to-back: a new request may be accepted in the same cycle done/err is high, so there are zero idle cycles between operations.
- Invariants:
  - WL and sram_rst are never high together.
  - BL never changes while any WL is high.
  - WL never rises in the same cycle BL changes.
- The cycle counter is sized ceil(log2(max(SETUP_CYCLES, PULSE_CYCLES)+1)) bits and reloads on every state entry. No wrap-around is possible.
- cfg_valid without cfg_ready: the request is held off; the block places no stability requirement on the inputs while they are not sampled.

Test Plan:
- Reset then write: RSTN 0 -> 1; send cfg_wl_addr = 3, cfg_data = 8'hA5.
  - Required: bl = A5 from edge+1; wl[3] high for cycles +2..+3; bl still A5 at +4; bl = 0 and done = 1 at +5; busy high for cycles +1..+4.
- Clear: cfg_clear = 1 with any address and data.
  - Required: sram_rst high for exactly 2 cycles; bl and wl stay 0; done = 1 after; a subsequent cell model reads all zeros.
- Out-of-range address: NUM_WL = 6, cfg_wl_addr = 7.
  - Required: busy for 1 cycle; err = 1 for 1 cycle; done = 0; wl never high; array unchanged.
- Back-to-back: hold cfg_valid high with writes to rows 0, 1, 7.
  - Required: each is accepted in the done cycle of the previous one; the wl one-hot sequence is 0 -> 1 -> 7; the assertion that no two wl bits are high at once never fires.
- Mid-operation reset: assert RSTN low during PULSE of a write to row 2.
  - Required: wl, bl and busy are 0 before the next edge; no done; after release cfg_ready = 1 and the next write completes normally.
- Parameter sweep: SETUP_CYCLES = 3, PULSE_CYCLES = 1.
  - Required: bl leads wl by 3 cycles; wl is a 1-cycle pulse; write latency is 5 cycles; all invariants hold.

Source files
------------

// File: rtl/bl_wl_programmer.sv
// Row programmer for a BL/WL-addressed configuration SRAM bank: one row write or
// whole-array clear per valid/ready handshake, with fixed setup/pulse/hold sequencing.
//
// state | meaning
// IDLE  | ready for a request; done/err pulse appears here after an operation
// SETUP | bit lines driven with row data, word lines low
// PULSE | selected word line high, bit lines held
// HOLD  | word line low again, bit lines still held for one cycle
// CLR   | shared cell reset asserted, bit and word lines low
// ERR   | one-cycle sink for an out-of-range row address
module bl_wl_programmer #(
    parameter int NUM_BL       = 8,
    parameter int NUM_WL       = 8,
    parameter int WL_ADDR_W    = 3,
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2
) (
    input  logic                 prog_clk,
    input  logic                 RSTN,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 cfg_clear,
    input  logic [WL_ADDR_W-1:0] cfg_wl_addr,
    input  logic [NUM_BL-1:0]    cfg_data,
    output logic [NUM_BL-1:0]    bl,
    output logic [NUM_WL-1:0]    wl,
    output logic                 sram_rst,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int MAX_CYC = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0]  SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [NUM_WL-1:0] WL_ONE     = {{(NUM_WL-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CLR   = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t                 state, state_d;
    logic [CNT_W-1:0]       cnt, cnt_d;
    logic [WL_ADDR_W-1:0]   addr_q, addr_d;
    logic [NUM_BL-1:0]      bl_d;
    logic [NUM_WL-1:0]      wl_d;
    logic                   rst_d, busy_d, done_d, err_d, ready_d;
    logic                   cnt_zero;

    assign cnt_zero = (cnt == '0);

    always_ff @(posedge prog_clk or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            bl        <= '0;
            wl        <= '0;
            sram_rst  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cfg_ready <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            addr_q    <= addr_d;
            bl        <= bl_d;
            wl        <= wl_d;
            sram_rst  <= rst_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            cfg_ready <= ready_d;
        end
    end

    // Outputs are computed for the next state and registered, so every line
    // changes only on a clock edge and the counter reloads on each state entry.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        bl_d    = bl;
        wl_d    = '0;
        rst_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state)
            IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    if (cfg_clear) begin
                        state_d = CLR;
                        cnt_d   = PULSE_LOAD;
                        rst_d   = 1'b1;
                        bl_d    = '0;
                    end else if (int'(cfg_wl_addr) >= NUM_WL) begin
                        state_d = ERR;
                        bl_d    = '0;
                    end else begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LOAD;
                        addr_d  = cfg_wl_addr;
                        bl_d    = cfg_data;
                    end
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                    wl_d    = WL_ONE << addr_q;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt - 1'b1;
                    wl_d  = WL_ONE << addr_q;
                end
            end
            HOLD: begin
                state_d = IDLE;
                bl_d    = '0;
                done_d  = 1'b1;
            end
            CLR: begin
                if (cnt_zero) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                    rst_d = 1'b1;
                end
            end
            ERR: begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
                bl_d    = '0;
            end
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
    end

endmodule

// File: tb/tb_bl_wl_programmer.sv
// Randomized bench for bl_wl_programmer: two instances (default timing, and a
// 6-row / SETUP=3 / PULSE=1 variant) checked cycle by cycle against a trace model.
module tb_bl_wl_programmer;

    logic       prog_clk = 1'b0;
    logic       RSTN;
    logic       valid_a, valid_b;
    logic       cfg_clear;
    logic [2:0] cfg_wl_addr;
    logic [7:0] cfg_data;

    logic       ready_a, rst_a, busy_a, done_a, err_a;
    logic [7:0] bl_a, wl_a;
    logic       ready_b, rst_b, busy_b, done_b, err_b;
    logic [7:0] bl_b;
    logic [5:0] wl_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic       cells_clr;
    logic [7:0] cells_a [8];
    logic [7:0] cells_b [6];
    logic [7:0] ref_a   [8];
    logic [7:0] ref_b   [6];

    logic       cur_b;
    logic [7:0] s_bl, s_wl;
    logic       s_rst, s_busy, s_done, s_err, s_ready;
    logic [7:0] prev_bl, prev_wl;

    always #5 prog_clk = ~prog_clk;

    bl_wl_programmer #(.NUM_BL(8), .NUM_WL(8), .WL_ADDR_W(3),
                       .SETUP_CYCLES(1), .PULSE_CYCLES(2)) dut_a (
        .prog_clk(prog_clk), .RSTN(RSTN), .cfg_valid(valid_a), .cfg_ready(ready_a),
        .cfg_clear(cfg_clear), .cfg_wl_addr(cfg_wl_addr), .cfg_data(cfg_data),
        .bl(bl_a), .wl(wl_a), .sram_rst(rst_a), .busy(busy_a), .done(done_a), .err(err_a));

    bl_wl_programmer #(.NUM_BL(8), .NUM_WL(6), .WL_ADDR_W(3),
                       .SETUP_CYCLES(3), .PULSE_CYCLES(1)) dut_b (
        .prog_clk(prog_clk), .RSTN(RSTN), .cfg_valid(valid_b), .cfg_ready(ready_b),
        .cfg_clear(cfg_clear), .cfg_wl_addr(cfg_wl_addr), .cfg_data(cfg_data),
        .bl(bl_b), .wl(wl_b), .sram_rst(rst_b), .busy(busy_b), .done(done_b), .err(err_b));

    assign s_bl    = cur_b ? bl_b : bl_a;
    assign s_wl    = cur_b ? {2'b00, wl_b} : wl_a;
    assign s_rst   = cur_b ? rst_b : rst_a;
    assign s_busy  = cur_b ? busy_b : busy_a;
    assign s_done  = cur_b ? done_b : done_a;
    assign s_err   = cur_b ? err_b : err_a;
    assign s_ready = cur_b ? ready_b : ready_a;

    // Cell arrays: a row follows the bit lines while its word line is high.
    always @(posedge prog_clk) begin
        for (int r = 0; r < 8; r++) begin
            if (cells_clr || rst_a) cells_a[r] <= '0;
            else if (wl_a[r])       cells_a[r] <= bl_a;
        end
        for (int r = 0; r < 6; r++) begin
            if (cells_clr || rst_b) cells_b[r] <= '0;
            else if (wl_b[r])       cells_b[r] <= bl_b;
        end
    end

    // Expected outputs k cycles after the handshake edge, derived from the
    // operation type and timing parameters; k == len is the done/err cycle.
    function automatic logic [20:0] exp_out(int k, int len, bit clr, int addr,
                                             logic [7:0] data, int s, int p, int nwl);
        logic [7:0] ebl, ewl;
        logic erst, ebusy, edone, eerr, erdy;
        ebl = '0; ewl = '0; erst = 0; edone = 0; eerr = 0;
        ebusy = (k < len);
        erdy  = (k == len);
        if (clr) begin
            if (k < len) erst = 1'b1;
            else         edone = 1'b1;
        end else if (addr >= nwl) begin
            if (k == len) eerr = 1'b1;
        end else begin
            if (k < len) ebl = data;
            if (k > s && k <= s + p) ewl = 8'(1 << addr);
            if (k == len) edone = 1'b1;
        end
        return {ebl, ewl, erst, ebusy, edone, eerr, erdy};
    endfunction

    task automatic run_op(input bit sel, input bit clr, input logic [2:0] addr,
                          input logic [7:0] data, input bit hold_valid,
                          input string tag, output int waited);
        int s, p, nwl, len;
        logic [20:0] got, want;
        s   = sel ? 3 : 1;
        p   = sel ? 1 : 2;
        nwl = sel ? 6 : 8;
        len = clr ? p + 1 : (int'(addr) >= nwl) ? 2 : s + p + 2;
        cur_b = sel;
        cfg_clear = clr; cfg_wl_addr = addr; cfg_data = data;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        waited = 0;
        while (!s_ready && waited < 50) begin
            @(negedge prog_clk);
            waited++;
        end
        n_cmp++;
        if (!s_ready) begin
            n_bad++;
            $display("FAIL %s handshake: cfg_ready=%b after %0d cycles, required 1", tag, s_ready, waited);
            valid_a = 1'b0; valid_b = 1'b0;
            return;
        end
        prev_bl = s_bl; prev_wl = s_wl;
        @(posedge prog_clk);
        for (int k = 1; k <= len; k++) begin
            @(negedge prog_clk);
            if (k == 1) begin
                if (!hold_valid) begin valid_a = 1'b0; valid_b = 1'b0; end
                cfg_clear   = 1'($urandom_range(0, 1));
                cfg_wl_addr = 3'($urandom_range(0, 7));
                cfg_data    = 8'($urandom_range(0, 255));
            end
            got  = {s_bl, s_wl, s_rst, s_busy, s_done, s_err, s_ready};
            want = exp_out(k, len, clr, int'(addr), data, s, p, nwl);
            n_cmp++;
            if (got !== want)
                begin
                n_bad++;
                $display("FAIL %s cycle+%0d: got bl=%h wl=%h rst=%b busy=%b done=%b err=%b rdy=%b, required bl=%h wl=%h rst=%b busy=%b done=%b err=%b rdy=%b",
                         tag, k, got[20:13], got[12:5], got[4], got[3], got[2], got[1], got[0],
                         want[20:13], want[12:5], want[4], want[3], want[2], want[1], want[0]);
            end
            n_cmp++;
            if ($countones(s_wl) > 1 || (s_wl != 0 && s_rst) ||
                (s_bl != prev_bl && (prev_wl != 0 || s_wl != 0))) begin
                n_bad++;
                $display("FAIL %s invariant cycle+%0d: bl %h->%h wl %h->%h rst=%b, required one-hot wl, no wl with rst, bl stable around wl",
                         tag, k, prev_bl, s_bl, prev_wl, s_wl, s_rst);
            end
            prev_bl = s_bl; prev_wl = s_wl;
        end
        for (int r = 0; r < nwl; r++) begin
            if (clr) begin
                if (sel) ref_b[r] = '0; else ref_a[r] = '0;
            end else if (r == int'(addr)) begin
                if (sel) ref_b[r] = data; else ref_a[r] = data;
            end
        end
    endtask

    task automatic check_cells(input bit sel, input string tag);
        for (int r = 0; r < (sel ? 6 : 8); r++) begin
            n_cmp++;
            if ((sel ? cells_b[r] : cells_a[r]) !== (sel ? ref_b[r] : ref_a[r])) begin
                n_bad++;
                $display("FAIL %s cells row %0d: got %h required %h", tag, r,
                         sel ? cells_b[r] : cells_a[r], sel ? ref_b[r] : ref_a[r]);
            end
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0; cells_clr = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        cfg_clear = 1'b0; cfg_wl_addr = '0; cfg_data = '0; cur_b = 1'b0;
        for (int r = 0; r < 8; r++) ref_a[r] = '0;
        for (int r = 0; r < 6; r++) ref_b[r] = '0;
        repeat (3) @(negedge prog_clk);
        n_cmp++;
        if ({bl_a, wl_a, rst_a, busy_a, done_a, err_a, ready_a,
             bl_b, wl_b, rst_b, busy_b, done_b, err_b, ready_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: a bl=%h wl=%h rst=%b busy=%b done=%b err=%b rdy=%b b bl=%h wl=%h rdy=%b, required all 0",
                     bl_a, wl_a, rst_a, busy_a, done_a, err_a, ready_a, bl_b, wl_b, ready_b);
        end
        RSTN = 1'b1; cells_clr = 1'b0;
        @(negedge prog_clk);
        n_cmp++;
        if ({ready_a, ready_b, busy_a, busy_b} !== 4'b1100) begin
            n_bad++;
            $display("FAIL reset_release: rdy_a=%b rdy_b=%b busy_a=%b busy_b=%b, required 1 1 0 0",
                     ready_a, ready_b, busy_a, busy_b);
        end
    endtask

    task automatic test_write_basic();
        int w;
        run_op(0, 0, 3'd3, 8'hA5, 0, "write_row3", w);
        check_cells(0, "write_row3");
    endtask

    task automatic test_clear();
        int w;
        run_op(0, 1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 0, "clear", w);
        check_cells(0, "clear");
    endtask

    task automatic test_random_a();
        int w;
        for (int i = 0; i < 12; i++) begin
            run_op(0, ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)),
                   8'($urandom_range(0, 255)), 0, "random_a", w);
            check_cells(0, "random_a");
        end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [2:0] rows [3];
        rows[0] = 3'd0; rows[1] = 3'd1; rows[2] = 3'd7;
        for (int i = 0; i < 3; i++) begin
            run_op(0, 0, rows[i], 8'($urandom_range(1, 255)), (i < 2), "back_to_back", w);
            if (i > 0) begin
                n_cmp++;
                if (w != 0) begin
                    n_bad++;
                    $display("FAIL back_to_back accept %0d: waited %0d idle cycles, required 0", i, w);
                end
            end
        end
        check_cells(0, "back_to_back");
    endtask

    task automatic test_error();
        int w;
        run_op(1, 0, 3'd7, 8'($urandom_range(0, 255)), 0, "err_addr7", w);
        run_op(1, 0, 3'd6, 8'($urandom_range(0, 255)), 0, "err_addr6", w);
        run_op(1, 0, 3'd5, 8'($urandom_range(0, 255)), 0, "row5_edge", w);
        check_cells(1, "error");
    endtask

    task automatic test_sweep_b();
        int w;
        run_op(1, 1, 3'd0, 8'hFF, 0, "sweep_clear", w);
        for (int i = 0; i < 12; i++) begin
            run_op(1, ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
                   8'($urandom_range(0, 255)), 0, "sweep", w);
            check_cells(1, "sweep");
        end
    endtask

    task automatic test_mid_reset();
        int w;
        logic [7:0] d;
        d = 8'($urandom_range(1, 255));
        cur_b = 1'b0;
        cfg_clear = 1'b0; cfg_wl_addr = 3'd2; cfg_data = d; valid_a = 1'b1;
        w = 0;
        while (!ready_a && w < 50) begin @(negedge prog_clk); w++; end
        @(posedge prog_clk);
        @(negedge prog_clk);
        valid_a = 1'b0;
        @(negedge prog_clk);
        n_cmp++;
        if (wl_a !== 8'h04) begin
            n_bad++;
            $display("FAIL mid_reset pulse: wl=%h required 04", wl_a);
        end
        #1 RSTN = 1'b0;
        #1;
        n_cmp++;
        if ({wl_a, bl_a, busy_a, done_a, ready_a} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset abort: wl=%h bl=%h busy=%b done=%b rdy=%b, required all 0",
                     wl_a, bl_a, busy_a, done_a, ready_a);
        end
        repeat (2) @(negedge prog_clk);
        RSTN = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge prog_clk);
            n_cmp++;
            if ({done_a, busy_a, ready_a} !== 3'b001) begin
                n_bad++;
                $display("FAIL mid_reset release: done=%b busy=%b rdy=%b, required 0 0 1",
                         done_a, busy_a, ready_a);
            end
        end
        run_op(0, 0, 3'd2, 8'($urandom_range(0, 255)), 0, "after_reset", w);
        check_cells(0, "after_reset");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_basic();
        test_clear();
        test_random_a();
        test_back_to_back();
        test_error();
        test_sweep_b();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
